// File: rtl/case_9_sdiv_26s_12s_seq.sv
// Sequential signed divider (radix-2 restoring, one quotient bit per cycle) that
// scales 14s x 12s products back down; valid/ready handshake on both sides.
module case_9_sdiv_26s_12s_seq #(
  parameter int ID         = 1,
  parameter int din0_WIDTH = 26,
  parameter int din1_WIDTH = 12,
  parameter int dout_WIDTH = din0_WIDTH
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [dout_WIDTH-1:0] dout,
  output logic signed [din1_WIDTH-1:0] rem,
  output logic                         div_by_zero,
  output logic                         overflow
);

  localparam int unsigned W0 = din0_WIDTH;
  localparam int unsigned W1 = din1_WIDTH;
  localparam int unsigned RW = din0_WIDTH + 1;
  localparam int unsigned CW = $clog2(din0_WIDTH);
  localparam logic [W0-1:0] MIN0 = {1'b1, {(W0-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W0-1:0] a;        // dividend magnitude, becomes quotient magnitude
  logic [RW-1:0] r;        // partial remainder
  logic [RW-1:0] b;        // divisor magnitude
  logic          s0, s1, dz, ov;
  logic [W1-1:0] dz_rem;

  logic [RW:0]   trial;
  logic          q_bit;
  logic [RW-1:0] r_nxt;
  logic [W0-1:0] mag0;
  logic [W1-1:0] mag1;

  // One restoring step plus operand magnitude extraction.
  always_comb begin
    trial = {r, a[W0-1]};
    q_bit = (trial >= {1'b0, b});
    r_nxt = q_bit ? RW'(trial - {1'b0, b}) : trial[RW-1:0];
    mag0  = din0[W0-1] ? W0'(-din0) : W0'(din0);
    mag1  = din1[W1-1] ? W1'(-din1) : W1'(din1);
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      dout        <= '0;
      rem         <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
      cnt         <= '0;
      a           <= '0;
      r           <= '0;
      b           <= '0;
      s0          <= 1'b0;
      s1          <= 1'b0;
      dz          <= 1'b0;
      ov          <= 1'b0;
      dz_rem      <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (in_valid && in_ready) begin
            s0       <= din0[W0-1];
            s1       <= din1[W1-1];
            a        <= mag0;
            b        <= RW'(mag1);
            dz       <= (din1 == '0);
            ov       <= (din0 == MIN0) && (din1 == '1);
            dz_rem   <= din0[W1-1:0];
            r        <= '0;
            cnt      <= CW'(W0 - 1);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          a   <= {a[W0-2:0], q_bit};
          r   <= r_nxt;
          cnt <= cnt - 1'b1;
          if (cnt == '0) state <= DONE;
        end
        DONE: begin
          // First DONE cycle applies signs and special cases; then hold until taken.
          if (!out_valid) begin
            out_valid <= 1'b1;
            if (dz) begin
              dout        <= '1;
              rem         <= dz_rem;
              div_by_zero <= 1'b1;
              overflow    <= 1'b0;
            end else if (ov) begin
              dout        <= MIN0;
              rem         <= '0;
              div_by_zero <= 1'b0;
              overflow    <= 1'b1;
            end else begin
              dout        <= (s0 ^ s1) ? W0'(-a) : a;
              rem         <= s0 ? W1'(-r[W1-1:0]) : r[W1-1:0];
              div_by_zero <= 1'b0;
              overflow    <= 1'b0;
            end
          end else if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_case_9_sdiv_26s_12s_seq.sv
// Self-checking bench for case_9_sdiv_26s_12s_seq: directed cases, then randomized
// handshake traffic against a C-semantics arithmetic reference.
module tb_case_9_sdiv_26s_12s_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [25:0] din0 = '0;
  logic [11:0] din1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [25:0] dout;
  logic [11:0] rem;
  logic        div_by_zero;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [25:0] q;
    logic [11:0] r;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t exp_q[$];

  case_9_sdiv_26s_12s_seq dut (
    .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .din0(din0), .din1(din1), .out_valid(out_valid), .out_ready(out_ready),
    .dout(dout), .rem(rem), .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Reference: C division on wide integers, with the two forced special cases.
  function automatic exp_t model(input logic [25:0] a, input logic [11:0] b);
    exp_t   e;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (sb == 0) begin
      e.q = '1; e.r = a[11:0]; e.dz = 1'b1; e.ov = 1'b0;
    end else begin
      e.q  = 26'(sa / sb);
      e.r  = 12'(sa % sb);
      e.dz = 1'b0;
      e.ov = (sa == -longint'(33554432)) && (sb == -1);
    end
    return e;
  endfunction

  function automatic logic [25:0] rnd0();
    case ($urandom_range(7))
      0:       return 26'h2000000;
      1:       return 26'd0;
      2:       return 26'($urandom_range(4095));
      default: return 26'($urandom);
    endcase
  endfunction

  function automatic logic [11:0] rnd1();
    case ($urandom_range(7))
      0:       return 12'd0;
      1:       return 12'hFFF;
      2:       return 12'h800;
      default: return 12'($urandom);
    endcase
  endfunction

  task automatic start(input string tag, input logic [25:0] a, input logic [11:0] b);
    int n = 0;
    while (!in_ready && n < 100) begin step(); n++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    din0 = a; din1 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input string tag);
    int n = 0;
    while (!out_valid && n < 100) begin step(); n++; end
    chk({tag, "_lat"}, 64'(n), 64'd27);
  endtask

  task automatic do_op(input string tag, input logic [25:0] a, input logic [11:0] b,
                       input logic [25:0] eq, input logic [11:0] er,
                       input logic edz, input logic eov);
    start(tag, a, b);
    wait_out(tag);
    chk({tag, "_q"}, 64'(dout), 64'(eq));
    chk({tag, "_r"}, 64'(rem), 64'(er));
    chk({tag, "_dz"}, 64'(div_by_zero), 64'(edz));
    chk({tag, "_ov"}, 64'(overflow), 64'(eov));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [13:0] f14;
    logic [11:0] f12;
    logic [25:0] prod, hold_q, pa;
    logic [11:0] hold_r, pb;
    exp_t        e;
    int          seen, accepted, checked, cyc;
    logic        acc, pop;

    // Reset state
    step(); step();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_dout", 64'(dout), 64'd0);
    chk("rst_rem", 64'(rem), 64'd0);
    chk("rst_dz", 64'(div_by_zero), 64'd0);
    chk("rst_ov", 64'(overflow), 64'd0);
    rst_n = 1'b1;
    chk("rel_in_ready_lo", 64'(in_ready), 64'd0);
    step();
    chk("rel_in_ready_hi", 64'(in_ready), 64'd1);

    // Basic signs
    do_op("pp", 26'd1000, 12'd7, 26'd142, 12'd6, 1'b0, 1'b0);
    do_op("np", -26'sd1000, 12'd7, -26'sd142, -12'sd6, 1'b0, 1'b0);
    do_op("pn", 26'd1000, -12'sd7, -26'sd142, 12'd6, 1'b0, 1'b0);
    do_op("nn", -26'sd1000, -12'sd7, 26'd142, -12'sd6, 1'b0, 1'b0);

    // Multiplier inverse
    do_op("inv", 26'd16777216, -12'sd2048, -26'sd8192, 12'd0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      f14  = 14'($urandom);
      f12  = 12'($urandom);
      if (f12 == 12'd0) f12 = 12'd1;
      prod = 26'($signed(f14) * $signed(f12));
      do_op("prod", prod, f12, {{12{f14[13]}}, f14}, 12'd0, 1'b0, 1'b0);
    end

    // Special cases
    do_op("dz", 26'd5, 12'd0, 26'h3FFFFFF, 12'd5, 1'b1, 1'b0);
    do_op("ovf", 26'h2000000, 12'hFFF, 26'h2000000, 12'd0, 1'b0, 1'b1);

    // Backpressure: result held, in_ready low, stray in_valid ignored
    start("bp", 26'd123456, 12'd100);
    wait_out("bp");
    hold_q = dout;
    hold_r = rem;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i == 4);
      din0 = 26'd999; din1 = 12'd3;
      step();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      chk("bp_q_stable", 64'(dout), 64'(hold_q));
      chk("bp_r_stable", 64'(rem), 64'(hold_r));
    end
    in_valid = 1'b0;
    chk("bp_q", 64'(dout), 64'd1234);
    chk("bp_r", 64'(rem), 64'd56);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("bp_hs_valid", 64'(out_valid), 64'd0);
    chk("bp_hs_in_ready", 64'(in_ready), 64'd0);
    step();
    chk("bp_post_in_ready", 64'(in_ready), 64'd1);
    chk("bp_no_spurious", 64'(out_valid), 64'd0);
    do_op("bp_next", -26'sd5000, 12'd33, -26'sd151, -12'sd17, 1'b0, 1'b0);

    // Reset at cycle 10 of CALC
    start("mr", 26'd777777, 12'd13);
    for (int i = 0; i < 10; i++) step();
    rst_n = 1'b0;
    #1;
    chk("mr_in_ready", 64'(in_ready), 64'd0);
    chk("mr_out_valid", 64'(out_valid), 64'd0);
    chk("mr_dout", 64'(dout), 64'd0);
    chk("mr_rem", 64'(rem), 64'd0);
    chk("mr_dz", 64'(div_by_zero), 64'd0);
    chk("mr_ov", 64'(overflow), 64'd0);
    step(); step();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (out_valid) seen++;
    end
    chk("mr_no_result", 64'(seen), 64'd0);
    do_op("mr_next", 26'd777777, 12'd13, 26'd59829, 12'd0, 1'b0, 1'b0);

    // Randomized back-to-back traffic with random valid/ready
    pa = rnd0(); pb = rnd1();
    accepted = 0; checked = 0; cyc = 0;
    while (checked < 1000 && cyc < 80000) begin
      in_valid  = (accepted < 1000) && ($urandom_range(3) != 0);
      din0      = pa;
      din1      = pb;
      out_ready = ($urandom_range(3) != 0);
      acc = in_valid && in_ready;
      pop = out_valid && out_ready;
      if (acc) begin
        exp_q.push_back(model(pa, pb));
        accepted++;
      end
      if (pop) begin
        chk("rnd_queue", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("rnd_q", 64'(dout), 64'(e.q));
          chk("rnd_r", 64'(rem), 64'(e.r));
          chk("rnd_dz", 64'(div_by_zero), 64'(e.dz));
          chk("rnd_ov", 64'(overflow), 64'(e.ov));
        end
        checked++;
      end
      step();
      cyc++;
      if (acc) begin pa = rnd0(); pb = rnd1(); end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("rnd_count", 64'(checked), 64'd1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
